// File: rtl/adder_pipe_hs_if.sv
// Handshake bundle for adder_pipe_hs: operand beat in, result beat out.
// The slave modport is the adder's view; master is the source/sink side.
interface adder_pipe_hs_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/adder_pipe_hs.sv
// Pipelined add/subtract unit with valid/ready handshake.
// The carry chain is cut into STAGES slices of WIDTH/STAGES bits; stage k adds
// slice k with the carry registered by stage k-1. The final stage register is
// the output register. Whole pipeline stalls together when the output is held.
// Optional build macro: ADDER_SAT_EN clamps sum to max-pos/min-neg on overflow.
module adder_pipe_hs #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  adder_pipe_hs_if.slave io
);
  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic             vld_q [STAGES];
  logic             vld_d [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];
  logic             c_q   [STAGES];
  logic             c_d   [STAGES];
  logic             ovf_q;
  logic             ovf_d;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Subtraction is a + ~b + 1; a borrow-in cancels the +1, hence cin ^ sub.
  assign b_eff   = io.b ^ {WIDTH{io.sub}};
  assign c0      = io.cin ^ io.sub;
  assign advance = !vld_q[LAST] || io.out_ready;

  assign io.in_ready  = advance;
  assign io.out_valid = vld_q[LAST];
  assign io.sum       = s_q[LAST];
  assign io.cout      = c_q[LAST];
  assign io.overflow  = ovf_q;

  // Next state for every stage: shift one step on advance, otherwise hold all (bubbles too)
  always_comb begin
    logic [WIDTH-1:0] a_src;
    logic [WIDTH-1:0] b_src;
    logic [WIDTH-1:0] s_src;
    logic             c_src;
    logic [SEG:0]     seg_sum;
    logic [WIDTH-1:0] s_new;
    int               km1;

    a_src   = '0;
    b_src   = '0;
    s_src   = '0;
    c_src   = 1'b0;
    seg_sum = '0;
    s_new   = '0;
    km1     = 0;
    ovf_d   = ovf_q;
    for (int k = 0; k < STAGES; k++) begin
      vld_d[k] = vld_q[k];
      a_d[k]   = a_q[k];
      b_d[k]   = b_q[k];
      s_d[k]   = s_q[k];
      c_d[k]   = c_q[k];
    end

    if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        km1 = (k > 0) ? k - 1 : 0;
        if (k == 0) begin
          vld_d[k] = io.in_valid;
          a_src    = io.a;
          b_src    = b_eff;
          s_src    = '0;
          c_src    = c0;
        end else begin
          vld_d[k] = vld_q[km1];
          a_src    = a_q[km1];
          b_src    = b_q[km1];
          s_src    = s_q[km1];
          c_src    = c_q[km1];
        end

        seg_sum = {1'b0, a_src[k*SEG +: SEG]} + {1'b0, b_src[k*SEG +: SEG]}
                + {{SEG{1'b0}}, c_src};
        s_new                = s_src;
        s_new[k*SEG +: SEG]  = seg_sum[SEG-1:0];

        a_d[k] = a_src;
        b_d[k] = b_src;
        c_d[k] = seg_sum[SEG];
        s_d[k] = s_new;

        // Full sum is only known in the last stage, so overflow (and any clamp) lives there
        if (k == LAST) begin
          ovf_d = (a_src[WIDTH-1] == b_src[WIDTH-1]) && (s_new[WIDTH-1] != a_src[WIDTH-1]);
`ifdef ADDER_SAT_EN
          if (ovf_d) begin
            s_d[k] = a_src[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
          end
`endif
        end
      end
    end
  end

  // Pipeline registers; async reset discards every in-flight beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= vld_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        s_q[k]   <= s_d[k];
        c_q[k]   <= c_d[k];
      end
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_adder_pipe_hs.sv
// Self-checking bench for adder_pipe_hs (WIDTH=16, STAGES=2).
// Directed vector table, backpressure and reset sequences, then random traffic
// against an arithmetic reference model with an in-order scoreboard.
module tb_adder_pipe_hs;
  localparam int W = 16;
  localparam int S = 2;

  logic clk;
  logic rst_n;

  adder_pipe_hs_if #(.WIDTH(W)) bus ();

  adder_pipe_hs #(.WIDTH(W), .STAGES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } res_t;

  vec_t vt[8];
  res_t exp_q[$];

  int total = 0;
  int bad   = 0;

  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_sum;
  logic         prev_co;
  logic         prev_ov;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    res_t   r;
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint mx = (longint'(1) << (W - 1)) - 1;
    longint mn = -(longint'(1) << (W - 1));
    longint ur;
    longint sr;
    if (sub) begin
      ur   = ua - ub - longint'(cin);
      sr   = sa - sb - longint'(cin);
      r.co = (ur >= 0);
    end else begin
      ur   = ua + ub + longint'(cin);
      sr   = sa + sb + longint'(cin);
      r.co = (ur >= (longint'(1) << W));
    end
    r.s  = ur[W-1:0];
    r.ov = (sr > mx) || (sr < mn);
`ifdef ADDER_SAT_EN
    if (r.ov) r.s = (sr > mx) ? mx[W-1:0] : mn[W-1:0];
`endif
    return r;
  endfunction

  // One cycle of traffic: drive at negedge, evaluate handshakes for the coming posedge
  task automatic cycle(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic icin, input logic isub, input logic iordy,
                       output logic acc);
    res_t e;
    @(negedge clk);
    if (prev_stall) begin
      chk("stall_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stall_hold_data", {14'd0, bus.sum, bus.cout, bus.overflow},
          {14'd0, prev_sum, prev_co, prev_ov});
    end
    bus.in_valid  = iv;
    bus.a         = ia;
    bus.b         = ib;
    bus.cin       = icin;
    bus.sub       = isub;
    bus.out_ready = iordy;
    #1;
    chk("in_ready_rule", {31'd0, bus.in_ready}, {31'd0, (!bus.out_valid || bus.out_ready)});
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("beat_result", {14'd0, bus.sum, bus.cout, bus.overflow}, {14'd0, e.s, e.co, e.ov});
      end
    end
    acc = bus.in_valid && bus.in_ready;
    if (acc) exp_q.push_back(model(ia, ib, icin, isub));
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_sum   = bus.sum;
    prev_co    = bus.cout;
    prev_ov    = bus.overflow;
  endtask

  task automatic drain();
    logic acc;
    int   n = 0;
    while ((exp_q.size() > 0 || bus.out_valid) && n < 60) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      n++;
    end
    chk("drain_empty", exp_q.size(), 32'd0);
    prev_stall = 1'b0;
  endtask

  // Single isolated beat from the table; checks latency and result
  task automatic run_single(input int i);
    int n;
    prev_stall = 1'b0;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a         = vt[i].a;
    bus.b         = vt[i].b;
    bus.cin       = vt[i].cin;
    bus.sub       = vt[i].sub;
    bus.out_ready = 1'b1;
    #1;
    chk({vt[i].name, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({vt[i].name, "_latency"}, n, S);
    chk({vt[i].name, "_sum"}, {16'd0, bus.sum}, {16'd0, vt[i].s});
    chk({vt[i].name, "_cout"}, {31'd0, bus.cout}, {31'd0, vt[i].co});
    chk({vt[i].name, "_ovf"}, {31'd0, bus.overflow}, {31'd0, vt[i].ov});
  endtask

  initial begin
    logic acc;
    int   sent;
    int   c;

    vt[0] = '{"add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
`ifdef ADDER_SAT_EN
    vt[1] = '{"add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vt[3] = '{"sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1};
    vt[7] = '{"add_negov", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b1};
`else
    vt[1] = '{"add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[3] = '{"sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vt[7] = '{"add_negov", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
`endif
    vt[2] = '{"sub_borrow", 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vt[4] = '{"slice_cry",  16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0};
    vt[5] = '{"wrap",       16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[6] = '{"sub_bin",    16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_outputs", {14'd0, bus.sum, bus.cout, bus.overflow}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    for (int i = 0; i < 8; i++) run_single(i);
    @(negedge clk);

    // Backpressure: 8 beats back-to-back, consumer stalls 5 cycles mid-stream
    sent = 0;
    c    = 0;
    prev_stall = 1'b0;
    while ((sent < 8 || exp_q.size() > 0) && c < 100) begin
      cycle(sent < 8, 16'(sent * 16'h1111), 16'(16'h0F0F + sent), sent[1], sent[0],
            !(c >= 3 && c < 8), acc);
      if (acc) sent++;
      c++;
    end
    chk("bp_sent", sent, 32'd8);
    chk("bp_all_out", exp_q.size(), 32'd0);
    drain();

    // Async reset with two beats in flight
    cycle(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, acc);
    cycle(1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0, 1'b1, acc);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("pre_rst_out_valid", {31'd0, bus.out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_out_valid", {31'd0, bus.out_valid}, 32'd0);
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_ghost", {31'd0, bus.out_valid}, 32'd0);
    end
    run_single(0);
    @(negedge clk);

    // Random traffic against the model
    prev_stall = 1'b0;
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
            ($urandom % 10) < 7, acc);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
